// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS boot instruction memory.
// Holds the controller states, default reset vector and NOP word.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [31:0] BASE_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mips_instr_memory_if.sv
// Loader handshake, CPU fetch port and status of the boot instruction memory.
// The master side loads/fetches; the slave side is the memory itself.
interface mips_instr_memory_if;

  logic        clk_enable;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        loaded;
  logic        fault;
  logic [15:0] fetch_count;

  modport master (
    output clk_enable,
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready,
    output instr_address,
    input  instr_readdata,
    input  loaded,
    input  fault,
    input  fetch_count
  );

  modport slave (
    input  clk_enable,
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready,
    input  instr_address,
    output instr_readdata,
    output loaded,
    output fault,
    output fetch_count
  );

endinterface

// File: rtl/mips_word_ram.sv
// Word storage: one synchronous write port, one combinational read port.
// Asynchronous clear returns every word to NOP.
module mips_word_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mips_instr_memory.sv
// Boot instruction memory: streams a program in, then serves CPU fetches.
// Illegal fetches latch a sticky fault until reset.
module mips_instr_memory
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH = 64,
  parameter logic [31:0] BASE  = BASE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  mips_instr_memory_if.slave bus
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          accept;
  logic          last_word;
  logic [31:0]   off;
  logic          in_win;
  logic          halt;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_data;

  // Offset is only trusted as an index once the window check passes.
  assign off    = bus.instr_address - BASE;
  assign in_win = (bus.instr_address >= BASE)
               && (off < SPAN)
               && (bus.instr_address[1:0] == 2'b00);
  assign halt   = (bus.instr_address == 32'h0);
  assign rd_idx = off[AW+1:2];

  assign accept    = (state_q == ST_LOAD)
                  && bus.load_valid
                  && bus.clk_enable;
  assign last_word = bus.load_last || (wr_ptr_q == LAST);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (bus.clk_enable) begin
      case (state_q)
        ST_LOAD: begin
          if (bus.load_valid) begin
            wr_ptr_d = wr_ptr_q + ONE;
            if (last_word) begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (in_win) begin
            cnt_d = sat_inc(cnt_q);
          end else if (!halt) begin
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_LOAD;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  mips_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (accept),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (bus.load_data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_comb begin
    bus.instr_readdata = NOP;
    unique case (1'b1)
      (state_q == ST_RUN) && in_win: bus.instr_readdata = rd_data;
      default:                       bus.instr_readdata = NOP;
    endcase
  end

  assign bus.load_ready  = (state_q == ST_LOAD);
  assign bus.loaded      = (state_q != ST_LOAD);
  assign bus.fault       = (state_q == ST_FAULT);
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_mips_instr_memory.sv
// Directed bench for mips_instr_memory: vector table plus
// hand sequences for load, fault, reset and saturation corners.
module tb_mips_instr_memory;

  logic clk;
  logic reset;

  mips_instr_memory_if bus();

  mips_instr_memory #(
    .DEPTH (64),
    .BASE  (32'hBFC0_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic [31:0] rd;
    logic        flt;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clk_enable    = 1'b1;
    bus.load_valid    = 1'b0;
    bus.load_data     = 32'h0;
    bus.load_last     = 1'b0;
    bus.instr_address = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #2;
    step();
    reset = 1'b1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    bus.clk_enable = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    step();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp,
                       input string nm);
    bus.instr_address = a;
    #1;
    chk(nm, bus.instr_readdata, exp);
  endtask

  initial begin
    vt[0] = '{1'b1, 32'hBFC0_0000, 32'h2484_004D, 1'b0};
    vt[1] = '{1'b1, 32'hBFC0_0004, 32'h2C82_000B, 1'b0};
    vt[2] = '{1'b1, 32'hBFC0_0008, 32'h0000_0008, 1'b0};
    vt[3] = '{1'b1, 32'hBFC0_000C, 32'h2400_0000, 1'b0};
    vt[4] = '{1'b1, 32'hBFC0_0010, 32'h0000_0000, 1'b0};
    vt[5] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vt[6] = '{1'b0, 32'hBFC0_0002, 32'h0000_0000, 1'b0};
    vt[7] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0};
    vt[8] = '{1'b1, 32'hBFC0_00FC, 32'h0000_0000, 1'b0};
    vt[9] = '{1'b0, 32'hBFC0_0100, 32'h0000_0000, 1'b0};

    idle_inputs();
    reset = 1'b0;
    #3;
    chk("rst_loaded", 32'(bus.loaded), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    chk("rst_ready", 32'(bus.load_ready), 32'h1);
    chk("rst_cnt", 32'(bus.fetch_count), 32'h0);
    fetch(32'hBFC0_0000, 32'h0, "rst_rd");
    step();
    reset = 1'b1;

    // Four-word program terminated by load_last.
    bus.instr_address = 32'h0;
    load_word(32'h2484_004D, 1'b0);
    load_word(32'h2C82_000B, 1'b0);
    load_word(32'h0000_0008, 1'b0);
    chk("ld3_loaded", 32'(bus.loaded), 32'h0);
    chk("ld3_ready", 32'(bus.load_ready), 32'h1);
    load_word(32'h2400_0000, 1'b1);
    chk("ld4_loaded", 32'(bus.loaded), 32'h1);
    chk("ld4_ready", 32'(bus.load_ready), 32'h0);
    fetch(32'hBFC0_0004, 32'h2C82_000B, "run_w1");

    for (int i = 0; i < 10; i++) begin
      bus.clk_enable = vt[i].en;
      fetch(vt[i].addr, vt[i].rd, $sformatf("vec%0d_rd", i));
      step();
      chk($sformatf("vec%0d_flt", i), 32'(bus.fault), 32'(vt[i].flt));
    end
    bus.clk_enable = 1'b1;
    bus.instr_address = 32'h0;
    chk("vec_cnt", 32'(bus.fetch_count), 32'd6);

    // Misaligned fetch faults on the next enabled edge and sticks.
    fetch(32'hBFC0_0002, 32'h0, "mis_rd");
    chk("mis_flt_pre", 32'(bus.fault), 32'h0);
    step();
    chk("mis_flt", 32'(bus.fault), 32'h1);
    fetch(32'hBFC0_0000, 32'h0, "flt_rd");
    step();
    chk("flt_sticky", 32'(bus.fault), 32'h1);
    chk("flt_loaded", 32'(bus.loaded), 32'h1);
    chk("flt_cnt", 32'(bus.fetch_count), 32'd6);

    // Full 64-word load without load_last.
    do_reset();
    chk("r2_fault", 32'(bus.fault), 32'h0);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) begin
        chk("ld63_loaded", 32'(bus.loaded), 32'h0);
      end
      load_word(32'hA500_0000 | 32'(i), 1'b0);
    end
    chk("ld64_loaded", 32'(bus.loaded), 32'h1);
    chk("ld64_ready", 32'(bus.load_ready), 32'h0);
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hFFFF_FFFF;
    #1;
    chk("ld65_ready", 32'(bus.load_ready), 32'h0);
    step();
    bus.load_valid = 1'b0;
    fetch(32'hBFC0_00FC, 32'hA500_003F, "w63_rd");
    fetch(32'hBFC0_0000, 32'hA500_0000, "w0_rd");
    fetch(32'hBFC0_0100, 32'h0, "top_rd");
    step();
    chk("top_flt", 32'(bus.fault), 32'h1);

    // Below-window address also faults.
    do_reset();
    load_word(32'h1234_5678, 1'b1);
    fetch(32'hBFBF_FFFC, 32'h0, "low_rd");
    step();
    chk("low_flt", 32'(bus.fault), 32'h1);

    // Reset in the middle of a load discards the partial program.
    do_reset();
    load_word(32'h1111_1111, 1'b0);
    load_word(32'h2222_2222, 1'b0);
    bus.instr_address = 32'hBFC0_0000;
    reset = 1'b0;
    #1;
    chk("mid_loaded", 32'(bus.loaded), 32'h0);
    chk("mid_ready", 32'(bus.load_ready), 32'h1);
    chk("mid_rd", bus.instr_readdata, 32'h0);
    step();
    reset = 1'b1;
    bus.instr_address = 32'h0;
    load_word(32'h3333_3333, 1'b1);
    fetch(32'hBFC0_0000, 32'h3333_3333, "rl_w0");
    fetch(32'hBFC0_0004, 32'h0, "rl_w1");
    bus.instr_address = 32'h0;

    // clk_enable low freezes the loader; then count saturation.
    do_reset();
    bus.clk_enable = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hDEAD_BEEF;
    bus.load_last  = 1'b1;
    repeat (3) step();
    chk("ce_loaded", 32'(bus.loaded), 32'h0);
    chk("ce_ready", 32'(bus.load_ready), 32'h1);
    load_word(32'hCAFE_F00D, 1'b1);
    fetch(32'hBFC0_0000, 32'hCAFE_F00D, "ce_w0");
    repeat (65534) step();
    chk("cnt_fffe", 32'(bus.fetch_count), 32'h0000_FFFE);
    repeat (70000 - 65534) step();
    chk("cnt_sat", 32'(bus.fetch_count), 32'h0000_FFFF);
    chk("cnt_flt", 32'(bus.fault), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_instr_memory.md
MIPS_INSTR_MEMORY -- requirements
Module: mips_instr_memory

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit instruction words held.
REQ-002 Parameter: BASE, 32'hBFC00000, byte address of word 0 (CPU reset vector).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 clk_enable  input  1  when low, no state changes (FSM, pointers, counters, memory frozen).
REQ-006 load_valid  input  1  loader presents a word.
REQ-007 load_data  input  32  instruction word to store.
REQ-008 load_last  input  1  qualifies the final word of the program.
REQ-009 load_ready  output  1  block can accept a loader word.
REQ-010 instr_address  input  32  CPU fetch byte address.
REQ-011 instr_readdata  output  32  fetched instruction, combinational from instr_address.
REQ-012 loaded  output  1  program load complete, fetches are served.
REQ-013 fault  output  1  sticky illegal-fetch flag.
REQ-014 fetch_count  output  16  in-window fetch cycles, saturating.

Function
REQ-015 FSM states SHALL be LOAD, RUN and FAULT; the reset state SHALL be LOAD.
REQ-016 In LOAD, load_ready SHALL be 1; a word is accepted on an edge with load_valid & load_ready & clk_enable and SHALL be written to mem[wr_ptr].
REQ-017 On each accept, wr_ptr SHALL increment by 1.
REQ-018 An accept with load_last=1, or an accept at wr_ptr==DEPTH-1, SHALL move LOAD->RUN; load_ready SHALL be 0 from that edge onward, so no overflow write is possible.
REQ-019 loaded SHALL be 1 exactly in RUN and FAULT.
REQ-020 Words never written SHALL read as 32'h00000000 (NOP).
REQ-021 In LOAD, instr_readdata SHALL be 0; the CPU is held in reset during loading.
REQ-022 In RUN, an in-window fetch SHALL return mem[(instr_address-BASE)>>2] in the same cycle, with zero latency.
REQ-023 In-window means BASE <= instr_address < BASE+4*DEPTH and instr_address[1:0]==0.
REQ-024 In RUN, instr_address==0 (halt address) SHALL return 0 and SHALL NOT raise fault.
REQ-025 In RUN, any other out-of-window or misaligned address SHALL return 0.
REQ-026 Such an address SHALL also move RUN->FAULT on the next enabled edge.
REQ-027 fault SHALL be 1 exactly in FAULT; FAULT SHALL be left only by reset, and instr_readdata SHALL be 0 there.
REQ-028 fetch_count SHALL increment on each enabled edge in RUN with an in-window address.
REQ-029 fetch_count SHALL saturate at 16'hFFFF.
REQ-030 Index arithmetic SHALL use (instr_address-BASE) truncated to clog2(DEPTH) bits after the in-window check; no wrap-around aliasing.

Reset
REQ-031 Asserting reset SHALL asynchronously force state=LOAD, wr_ptr=0, fetch_count=0, loaded=0, fault=0, load_ready=1.
REQ-032 All memory words SHALL reset to 0; reset mid-load discards any partial program.
REQ-033 Deassertion SHALL take effect at the next rising edge of clk.

Structure
REQ-034 The state enum, BASE default and the NOP constant (32'h0) SHALL live in a shared package, mips_mem_pkg.
REQ-035 The storage array SHALL be one sub-module, mips_word_ram: one synchronous write port, one combinational read port, asynchronous clear.

Verification
REQ-036 Load 2484004D, 2C82000B, 00000008, 24000000 with load_last on the 4th word -> loaded=1 and load_ready=0 after the 4th edge; then address BFC00004 reads 2C82000B.
REQ-037 In RUN: address BFC00010 reads 0 with fault=0; address 0 reads 0 with fault=0; address BFC00002 reads 0 and fault=1 after the next edge, and later address BFC00000 still reads 0.
REQ-038 Load 64 words with load_last=0 -> auto RUN after the 64th accept; a 65th load_valid is not accepted; address BFC000FC reads word 63.
REQ-039 Assert reset after 2 accepted words -> loaded=0, wr_ptr=0, and after reload BFC00000 reads the new word 0.
REQ-040 Hold clk_enable=0 during load_valid=1 -> no accept, wr_ptr unchanged; 70000 in-window RUN cycles -> fetch_count=FFFF.
